// File: rtl/mux21_2bits_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux21_2bits_rr_arbiter
//
// Purpose:
//   Upstream stage for the gate-level 2:1 two-bit multiplexer. Two
//   valid/ready producers compete for a single-entry output holding
//   register. The winner's word is registered. `selector` reports which
//   source the held word came from and drives the mux select line.
//   Contention is resolved round-robin. Backpressure from the consumer
//   reaches each source through its ready.
//
// Optional feature:
//   `define MUX21_RR_ARBITER_FIXED_PRIO_EN selects fixed-priority
//   arbitration. In that mode source 0 always wins contention, and the
//   last-grant register is not built.
//
// Parameters:
//   DATA_W     - width of each data word and of out_data (>= 1)
//   RESET_LAST - last-grant value after reset. The default of 1 makes
//                source 0 win the first contested cycle.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                synchronous, active-high reset
//   in0_valid/in0_data   source 0 word offer
//   in0_ready            source 0 word accepted this cycle
//   in1_valid/in1_data   source 1 word offer
//   in1_ready            source 1 word accepted this cycle
//   out_valid            holding register contains a word
//   out_data             held word
//   out_ready            consumer takes the held word this cycle
//   selector             source index of the held word (mux select)
// ---------------------------------------------------------------------------
module mux21_2bits_rr_arbiter #(
  parameter int DATA_W     = 2,
  parameter bit RESET_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              selector
);

  // State is encoded as {out_valid, selector}.
  // A drain keeps the selector of the last held word, so the empty
  // condition has two encodings. Both encodings mean "empty".
  typedef enum logic [1:0] {
    ST_EMPTY_S0 = 2'b00,
    ST_EMPTY_S1 = 2'b01,
    ST_FULL0    = 2'b10,
    ST_FULL1    = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              grant_valid;
  logic              grant_idx;
  logic              space;
  logic              xfer;

`ifndef MUX21_RR_ARBITER_FIXED_PRIO_EN
  logic last_grant_q, last_grant_d;
`endif

  // Grant selection. When both sources are valid, round-robin picks the
  // source that did not win the last actual transfer.
  always_comb begin
    grant_valid = in0_valid | in1_valid;
    grant_idx   = 1'b0;
    if (in0_valid && in1_valid) begin
`ifdef MUX21_RR_ARBITER_FIXED_PRIO_EN
      grant_idx = 1'b0;
`else
      grant_idx = ~last_grant_q;
`endif
    end else if (in1_valid) begin
      grant_idx = 1'b1;
    end
  end

  // The register can accept a word when it is empty or is being drained
  // in the same cycle. Reset blocks any acceptance.
  assign space = ~state_q[1] | out_ready;
  assign xfer  = grant_valid & space & ~reset;

  // Next-state and datapath logic.
  // A fill takes precedence over a drain in the same cycle.
  // A drain with no fill clears only the valid bit.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    if (xfer) begin
      state_d    = state_e'({1'b1, grant_idx});
      out_data_d = grant_idx ? in1_data : in0_data;
    end else if (state_q[1] && out_ready) begin
      state_d = state_e'({1'b0, state_q[0]});
    end
  end

`ifndef MUX21_RR_ARBITER_FIXED_PRIO_EN
  // Priority rotates only on a real transfer.
  // Idle and stalled cycles leave it unchanged.
  always_comb begin
    last_grant_d = last_grant_q;
    if (xfer) begin
      last_grant_d = grant_idx;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY_S0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
    end
  end

`ifndef MUX21_RR_ARBITER_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= RESET_LAST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Output decode. Ready is the transfer qualifier steered to the winner.
  // As a result, at most one ready is high, and never without its valid.
  always_comb begin
    out_valid = state_q[1];
    selector  = state_q[0];
    out_data  = out_data_q;
    in0_ready = xfer & ~grant_idx;
    in1_ready = xfer & grant_idx;
  end

endmodule

// File: tb/tb_mux21_2bits_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux21_2bits_rr_arbiter
//
// Self-checking bench for mux21_2bits_rr_arbiter (DATA_W = 2).
// Stimulus is applied at the falling edge. Readies are sampled shortly
// after the inputs settle. Registered outputs are sampled 1 time unit
// after the rising edge. A behavioural model of the holding register
// predicts every value. The model uses plain variables: one word slot,
// the source of that word, and the priority holder.
// ---------------------------------------------------------------------------
module tb_mux21_2bits_rr_arbiter;

  localparam int DATA_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in0_valid, in1_valid;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              in0_ready, in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              selector;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit       m_full;
  bit [1:0] m_word;
  bit       m_src;
  bit       m_prio_holder;

  mux21_2bits_rr_arbiter #(.DATA_W(DATA_W), .RESET_LAST(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .selector  (selector)
  );

  always #5 clk = ~clk;

  // Safety net so that the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, checks the readies against the model,
  // clocks the DUT, advances the model, and checks the registered outputs.
  task automatic applyStimulus(input bit r, input bit v0, input bit [1:0] d0,
                               input bit v1, input bit [1:0] d1, input bit ordy);
    bit room, winner, take0, take1;
    @(negedge clk);
    reset = r; in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1; out_ready = ordy;
    #1;
    room = !m_full || ordy;
`ifdef MUX21_RR_ARBITER_FIXED_PRIO_EN
    winner = (v0 && v1) ? 1'b0 : v1;
`else
    winner = (v0 && v1) ? !m_prio_holder : v1;
`endif
    take0 = !r && room && v0 && (winner == 1'b0);
    take1 = !r && room && v1 && (winner == 1'b1);
    checkOutput("in0_ready", {7'd0, in0_ready}, {7'd0, take0});
    checkOutput("in1_ready", {7'd0, in1_ready}, {7'd0, take1});
    @(posedge clk);
    if (r) begin
      m_full = 0; m_word = 0; m_src = 0; m_prio_holder = 1;
    end else if (take0 || take1) begin
      m_full = 1; m_src = take1; m_word = take1 ? d1 : d0; m_prio_holder = take1;
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    #1;
    checkOutput("out_valid", {7'd0, out_valid}, {7'd0, m_full});
    checkOutput("out_data", {6'd0, out_data}, {6'd0, m_word});
    checkOutput("selector", {7'd0, selector}, {7'd0, m_src});
  endtask

  initial begin
    logic [1:0] seq_data [4];
    logic       seq_sel  [4];
    reset = 1; in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; out_ready = 0;
    m_full = 0; m_word = 0; m_src = 0; m_prio_holder = 1;

    // Test 1: reset with a pending word, then first acceptance.
    applyStimulus(1, 1, 2'b11, 0, 2'b00, 1);
    applyStimulus(1, 1, 2'b11, 0, 2'b00, 1);
    checkOutput("t1_rst_valid", {7'd0, out_valid}, 8'd0);
    checkOutput("t1_rst_data", {6'd0, out_data}, 8'd0);
    applyStimulus(0, 1, 2'b11, 0, 2'b00, 1);
    checkOutput("t1_first_data", {6'd0, out_data}, 8'h3);
    checkOutput("t1_first_sel", {7'd0, selector}, 8'd0);

    // Test 2: both sources continuously valid. Checked against fixed sequences.
`ifdef MUX21_RR_ARBITER_FIXED_PRIO_EN
    seq_data = '{2'b01, 2'b01, 2'b01, 2'b01};
    seq_sel  = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    seq_data = '{2'b01, 2'b10, 2'b01, 2'b10};
    seq_sel  = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    applyStimulus(1, 0, 2'b00, 0, 2'b00, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 2'b01, 1, 2'b10, 1);
      checkOutput("t2_seq_data", {6'd0, out_data}, {6'd0, seq_data[i]});
      checkOutput("t2_seq_sel", {7'd0, selector}, {7'd0, seq_sel[i]});
    end

    // Test 3: only source 1 is active.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 2'b00, 1, 2'b10, 1);
      checkOutput("t3_sel", {7'd0, selector}, 8'd1);
    end

    // Test 4: stall with both sources valid, then drain and fill in the same cycle.
    applyStimulus(1, 0, 2'b00, 0, 2'b00, 0);
    applyStimulus(0, 1, 2'b01, 0, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 2'b00, 1, 2'b11, 0);
      checkOutput("t4_hold_data", {6'd0, out_data}, 8'h1);
    end
    applyStimulus(0, 1, 2'b00, 1, 2'b11, 1);

    // Test 5: single word, then drain with no fill.
    // Priority must be unchanged by the drain.
    applyStimulus(1, 0, 2'b00, 0, 2'b00, 0);
    applyStimulus(0, 0, 2'b00, 1, 2'b10, 0);
    applyStimulus(0, 0, 2'b00, 0, 2'b00, 1);
    checkOutput("t5_drain_data", {6'd0, out_data}, 8'h2);
    applyStimulus(0, 0, 2'b00, 0, 2'b00, 1);
    applyStimulus(0, 1, 2'b01, 1, 2'b11, 1);

    // Test 6: reset while full. No transfer happens in the reset cycle.
    applyStimulus(0, 0, 2'b00, 1, 2'b10, 0);
    applyStimulus(1, 1, 2'b11, 1, 2'b01, 0);
    checkOutput("t6_valid", {7'd0, out_valid}, 8'd0);
    checkOutput("t6_data", {6'd0, out_data}, 8'd0);

    // Randomised traffic, with an occasional reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) != 0), 2'($urandom),
                    ($urandom_range(0, 3) != 0), 2'($urandom),
                    ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
